// File: rtl/compare4.sv
// compare4: registered 4-bit unsigned magnitude comparator
// built from two combinational 2-bit comparator slices.

// compare2: stateless 2-bit unsigned comparator slice.
module compare2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       more,
    output logic       less
);

    logic w_eq_hi;

    assign w_eq_hi = (a[1] == b[1]);

    // Decide on the MSB first, fall back to the LSB when the MSBs tie.
    always_comb begin
        more = (a[1] & ~b[1]) | (w_eq_hi & a[0] & ~b[0]);
        less = (~a[1] & b[1]) | (w_eq_hi & ~a[0] & b[0]);
    end

endmodule

module compare4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       MORE,
    output logic       LESS
);

    logic w_more_hi;
    logic w_less_hi;
    logic w_more_lo;
    logic w_less_lo;
    logic w_hi_tie;
    logic w_more_nx;
    logic w_less_nx;
    logic r_more;
    logic r_less;

    compare2 u_hi (
        .a    (a[3:2]),
        .b    (b[3:2]),
        .more (w_more_hi),
        .less (w_less_hi)
    );

    compare2 u_lo (
        .a    (a[1:0]),
        .b    (b[1:0]),
        .more (w_more_lo),
        .less (w_less_lo)
    );

    // The low slice only matters when the high halves tie.
    always_comb begin
        w_hi_tie  = ~w_more_hi & ~w_less_hi;
        w_more_nx = w_more_hi | (w_hi_tie & w_more_lo);
        w_less_nx = w_less_hi | (w_hi_tie & w_less_lo);
    end

    // Register the flags; reset wins over the compare result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_more <= 1'b0;
            r_less <= 1'b0;
        end else begin
            r_more <= w_more_nx;
            r_less <= w_less_nx;
        end
    end

    assign MORE = r_more;
    assign LESS = r_less;

endmodule

// File: tb/tb_compare4.sv
// tb_compare4: scoreboard bench for compare4 and a
// standalone combinational sweep of compare2.
module tb_compare4;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       MORE;
    logic       LESS;

    logic [1:0] c2_a;
    logic [1:0] c2_b;
    logic       c2_more;
    logic       c2_less;

    logic [1:0] q_exp [$];
    int         n_tests;
    int         n_fail;

    compare4 dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .MORE (MORE),
        .LESS (LESS)
    );

    compare2 u_c2 (
        .a    (c2_a),
        .b    (c2_b),
        .more (c2_more),
        .less (c2_less)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus, queue its expected flags,
    // then step past the edge so outputs can be sampled.
    task automatic drive(input logic [3:0] ia, input logic [3:0] ib,
                         input logic irst);
        logic [1:0] e;
        a   = ia;
        b   = ib;
        rst = irst;
        if (irst) e = 2'b00;
        else      e = {(ia > ib), (ia < ib)};
        q_exp.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [1:0] e;
        drive(4'hF, 4'h0, 1'b1);
        e = q_exp.pop_front();
        n_tests++;
        if ({MORE, LESS} !== e) begin
            n_fail++;
            $display("FAIL reset: got %b want %b", {MORE, LESS}, e);
        end
    endtask

    task automatic test_sweep;
        logic [1:0] e;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = i[7:0];
            drive(v[3:0], v[7:4], 1'b0);
            e = q_exp.pop_front();
            n_tests++;
            if ({MORE, LESS} !== e) begin
                n_fail++;
                $display("FAIL sweep a=%0d b=%0d: got %b want %b",
                         v[3:0], v[7:4], {MORE, LESS}, e);
            end
            n_tests++;
            if ((MORE & LESS) !== 1'b0) begin
                n_fail++;
                $display("FAIL exclusive a=%0d b=%0d: got %b want not 11",
                         v[3:0], v[7:4], {MORE, LESS});
            end
        end
    endtask

    task automatic test_directed;
        logic [3:0] ta [6];
        logic [3:0] tb [6];
        logic [1:0] tw [6];
        logic [1:0] e;
        ta = '{4'b1010, 4'b1000, 4'b0100, 4'b0110, 4'h0, 4'hF};
        tb = '{4'b1010, 4'b0111, 4'b1011, 4'b0101, 4'hF, 4'h0};
        tw = '{2'b00,   2'b10,   2'b01,   2'b10,   2'b01, 2'b10};
        for (int i = 0; i < 6; i++) begin
            drive(ta[i], tb[i], 1'b0);
            e = q_exp.pop_front();
            n_tests++;
            if ({MORE, LESS} !== tw[i]) begin
                n_fail++;
                $display("FAIL directed a=%b b=%b: got %b want %b",
                         ta[i], tb[i], {MORE, LESS}, tw[i]);
            end
            n_tests++;
            if ({MORE, LESS} !== e) begin
                n_fail++;
                $display("FAIL directed_sb a=%b b=%b: got %b want %b",
                         ta[i], tb[i], {MORE, LESS}, e);
            end
        end
        drive(4'hF, 4'hF, 1'b0);
        e = q_exp.pop_front();
        n_tests++;
        if ({MORE, LESS} !== 2'b00) begin
            n_fail++;
            $display("FAIL boundary_ff: got %b want 00", {MORE, LESS});
        end
    endtask

    task automatic test_reset_midstream;
        logic [1:0] e;
        drive(4'hF, 4'h0, 1'b0);
        e = q_exp.pop_front();
        n_tests++;
        if ({MORE, LESS} !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_pre: got %b want 10", {MORE, LESS});
        end
        drive(4'hF, 4'h0, 1'b1);
        e = q_exp.pop_front();
        n_tests++;
        if ({MORE, LESS} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_rst: got %b want 00", {MORE, LESS});
        end
        drive(4'hF, 4'h0, 1'b0);
        e = q_exp.pop_front();
        n_tests++;
        if ({MORE, LESS} !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_post: got %b want 10", {MORE, LESS});
        end
    endtask

    task automatic test_compare2;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            logic [1:0] w;
            v    = i[3:0];
            c2_a = v[1:0];
            c2_b = v[3:2];
            w    = {(v[1:0] > v[3:2]), (v[1:0] < v[3:2])};
            #1;
            n_tests++;
            if ({c2_more, c2_less} !== w) begin
                n_fail++;
                $display("FAIL compare2 a=%0d b=%0d: got %b want %b",
                         v[1:0], v[3:2], {c2_more, c2_less}, w);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        a       = 4'h0;
        b       = 4'h0;
        c2_a    = 2'b00;
        c2_b    = 2'b00;
        test_compare2();
        @(negedge clk);
        test_reset();
        test_sweep();
        test_directed();
        test_reset_midstream();
        n_tests++;
        if (q_exp.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d want 0", q_exp.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
